// File: rtl/ascii_pkg.sv
// Shared ASCII case constants and helpers, used by both the lower-case and
// upper-case stream converters.
package ascii_pkg;

  localparam logic [7:0] ASCII_UC_A     = 8'h41;
  localparam logic [7:0] ASCII_UC_Z     = 8'h5A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= ASCII_UC_A) && (b <= ASCII_UC_Z);
  endfunction

  // Only 'A'..'Z' change; punctuation and high-bit bytes pass untouched.
  function automatic logic [7:0] to_lower(input logic [7:0] b);
    return is_upper(b) ? (b | ASCII_CASE_BIT) : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy count. The head entry is
// presented combinationally on rd_data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: every output of an always_comb gets a default before any branch;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // NOTE: storage is deliberately not reset; the count guarantees stale
  // entries are never presented, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ascii_to_lower_stream.sv
// Streaming ASCII lower-case converter: converts on the write path into a
// small FIFO and counts how many bytes were actually changed.
module ascii_to_lower_stream
  import ascii_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] conv_count,
  input  logic             cnt_clear
);

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Readiness depends only on full, so a pop cannot open a slot in the same
  // cycle; this keeps in_ready free of any path from out_ready.
  assign in_ready  = rst_n & ~full;
  assign out_valid = rst_n & ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (to_lower(in_data)),
    .pop     (pop),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty)
  );

  // Clear wins over a same-cycle converting push.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clear) begin
      conv_count <= '0;
    end else if (push && is_upper(in_data) && (conv_count != '1)) begin
      conv_count <= conv_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ascii_to_lower_stream.sv
// Directed scoreboard bench: expected bytes are queued when a push is driven
// and compared when the DUT pops them. A second instance with CNT_W=2 shares
// all stimulus to exercise counter saturation.
module tb_ascii_to_lower_stream;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        cnt_clear = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] conv_count;
  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [7:0]  sat_out_data;
  logic [1:0]  sat_conv_count;

  always #5 clk = ~clk;

  ascii_to_lower_stream #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .conv_count (conv_count),
    .cnt_clear  (cnt_clear)
  );

  ascii_to_lower_stream #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (sat_in_ready),
    .in_data    (in_data),
    .out_valid  (sat_out_valid),
    .out_ready  (out_ready),
    .out_data   (sat_out_data),
    .conv_count (sat_conv_count),
    .cnt_clear  (cnt_clear)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  int unsigned exp_cnt     = 0;
  int unsigned exp_cnt_sat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_lower(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction

  // One clock of stimulus; all observations happen at the falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic clr);
    logic model_ready;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    cnt_clear = clr;
    @(negedge clk);
    model_ready = (exp_q.size() < DEPTH);
    check("in_ready", in_ready, model_ready);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("conv_count", conv_count, exp_cnt);
    check("conv_count_sat", sat_conv_count, exp_cnt_sat);
    check("sat_out_valid", sat_out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0 && !r) check("hold_data", out_data, exp_q[0]);
    if (out_valid && out_ready) begin
      check("pop_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
    end
    if (v && model_ready) begin
      exp_q.push_back(model_lower(d));
    end
    if (clr) begin
      exp_cnt     = 0;
      exp_cnt_sat = 0;
    end else if (v && model_ready && (d >= 8'h41 && d <= 8'h5A)) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt_sat < 3) exp_cnt_sat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clear = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_cnt     = 0;
    exp_cnt_sat = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_conv_count", conv_count, 16'd0);
    check("rst_conv_count_sat", sat_conv_count, 2'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_out_valid", out_valid, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] bnd [6];
    bnd = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h61, 8'hC1};

    // 1: reset, single 'H'
    do_reset();
    cycle(1'b1, 8'h48, 1'b1, 1'b0);
    check("s1_out_valid", out_valid, 1'b1);
    check("s1_out_data", out_data, 8'h68);
    check("s1_conv_count", conv_count, 16'd1);
    drain(2);

    // 2: conversion boundaries, counted from a cleared counter
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, bnd[i], 1'b1, 1'b0);
    drain(3);
    check("s2_conv_count", conv_count, 16'd2);

    // 3: fill with sink stalled, refused push, pop-while-full, ordered drain
    cycle(1'b1, 8'h61, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    cycle(1'b1, 8'h63, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    check("s3_full_in_ready", in_ready, 1'b0);
    cycle(1'b1, 8'h58, 1'b0, 1'b0);
    cycle(1'b1, 8'h59, 1'b1, 1'b0);
    check("s3_after_pop_in_ready", in_ready, 1'b1);
    drain(5);
    check("s3_empty", exp_q.size(), 0);

    // 4: continuous streaming across several pointer wraps
    for (int i = 0; i < 3 * DEPTH; i++) cycle(1'b1, 8'h41 + 8'(i * 2), 1'b1, 1'b0);
    drain(2);
    check("s4_out_valid_idle", out_valid, 1'b0);

    // 5: clear beats a converting push; narrow counter saturates
    cycle(1'b1, 8'h5A, 1'b1, 1'b1);
    check("s5_clear_priority", conv_count, 16'd0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h4B + 8'(i), 1'b1, 1'b0);
    drain(2);
    check("s5_count", conv_count, 16'd5);
    check("s5_saturated", sat_conv_count, 2'd3);

    // 6: mid-stream reset with three bytes buffered
    cycle(1'b1, 8'h51, 1'b0, 1'b0);
    cycle(1'b1, 8'h72, 1'b0, 1'b0);
    cycle(1'b1, 8'h53, 1'b0, 1'b0);
    check("s6_buffered_valid", out_valid, 1'b1);
    do_reset();
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    check("s6_post_reset_data", out_data, 8'h7A);
    drain(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
